// File: rtl/bus_demux_8085_if.sv
// 8085 demultiplexed bus bundle: core-side strobes and address/data tap,
// plus the latched address, chip selects and READY returned to the core.
interface bus_demux_8085_if;
    logic [7:0]  AD;
    logic [7:0]  A;
    logic        ALE;
    logic        RDn;
    logic        WRn;
    logic        IO_Mn;
    logic [15:0] ADDR;
    logic        ROM_CSn;
    logic        RAM_CSn;
    logic        IO_CSn;
    logic        IO_Mn_L;
    logic        UNMAPPED;
    logic        READY;

    modport master (
        output AD, A, ALE, RDn, WRn, IO_Mn,
        input  ADDR, ROM_CSn, RAM_CSn, IO_CSn, IO_Mn_L, UNMAPPED, READY
    );

    modport slave (
        input  AD, A, ALE, RDn, WRn, IO_Mn,
        output ADDR, ROM_CSn, RAM_CSn, IO_CSn, IO_Mn_L, UNMAPPED, READY
    );
endinterface

// File: rtl/bus_demux_8085.sv
// 8085 bus front end: ALE address latch, registered region decode and
// per-region wait-state READY generation.
module bus_demux_8085 #(
    parameter logic [4:0] ROM_BASE = 5'b00000,
    parameter logic [7:0] RAM_PAGE = 8'h20,
    parameter logic [3:0] IO_BASE  = 4'h0,
    parameter logic [3:0] ROM_WAIT = 4'd1,
    parameter logic [3:0] RAM_WAIT = 4'd0,
    parameter logic [3:0] IO_WAIT  = 4'd2
) (
    input logic               CLK,
    input logic               RESET,
    bus_demux_8085_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_RELEASE} state_t;

    state_t      state, state_next;
    logic [15:0] addr;
    logic        io_m_l;
    logic        rom_csn, ram_csn, io_csn;
    logic        unmapped;
    logic        ready, ready_next;
    logic [3:0]  cnt, cnt_next;

    logic        stb;
    logic [15:0] addr_in;
    logic        rom_hit, ram_hit, io_hit;
    logic [3:0]  sel_wait;

    assign stb     = ~bus.RDn | ~bus.WRn;
    assign addr_in = {bus.A, bus.AD};

    // Decode is taken from the incoming address so the selects land on the ALE edge.
    always_comb begin
        rom_hit = ~bus.IO_Mn & (addr_in[15:11] == ROM_BASE);
        ram_hit = ~bus.IO_Mn & (addr_in[15:8] == RAM_PAGE) & ~rom_hit;
        io_hit  =  bus.IO_Mn & (addr_in[7:4] == IO_BASE);
    end

    always_comb begin
        if (!rom_csn)      sel_wait = ROM_WAIT;
        else if (!ram_csn) sel_wait = RAM_WAIT;
        else if (!io_csn)  sel_wait = IO_WAIT;
        else               sel_wait = '0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            ready    <= 1'b1;
            cnt      <= '0;
            addr     <= '0;
            io_m_l   <= 1'b0;
            rom_csn  <= 1'b1;
            ram_csn  <= 1'b1;
            io_csn   <= 1'b1;
            unmapped <= 1'b0;
        end else begin
            state <= state_next;
            ready <= ready_next;
            cnt   <= cnt_next;
            if (bus.ALE) begin
                addr     <= addr_in;
                io_m_l   <= bus.IO_Mn;
                rom_csn  <= ~rom_hit;
                ram_csn  <= ~ram_hit;
                io_csn   <= ~io_hit;
                unmapped <= ~(rom_hit | ram_hit | io_hit);
            end
        end
    end

    always_comb begin
        state_next = state;
        if (bus.ALE) begin
            state_next = S_ADDR;
        end else begin
            case (state)
                S_IDLE:    state_next = S_IDLE;
                S_ADDR:    if (stb) state_next = (sel_wait == '0) ? S_RELEASE : S_WAIT;
                S_WAIT:    if (cnt <= 4'd1) state_next = S_RELEASE;
                S_RELEASE: if (!stb) state_next = S_IDLE;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_next = ready;
        cnt_next   = cnt;
        if (bus.ALE) begin
            ready_next = 1'b1;
            cnt_next   = '0;
        end else begin
            case (state)
                S_ADDR: begin
                    if (stb && sel_wait != '0) begin
                        ready_next = 1'b0;
                        cnt_next   = sel_wait;
                    end
                end
                S_WAIT: begin
                    cnt_next = cnt - 4'd1;
                    if (cnt <= 4'd1) ready_next = 1'b1;
                end
                default: ready_next = 1'b1;
            endcase
        end
    end

    assign bus.ADDR     = addr;
    assign bus.IO_Mn_L  = io_m_l;
    assign bus.ROM_CSn  = rom_csn;
    assign bus.RAM_CSn  = ram_csn;
    assign bus.IO_CSn   = io_csn;
    assign bus.UNMAPPED = unmapped;
    assign bus.READY    = ready;

endmodule

// File: tb/tb_bus_demux_8085.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected
// outputs; a negedge monitor pops and compares against the DUT.
module tb_bus_demux_8085;

    localparam int ROM_W = 1;
    localparam int RAM_W = 0;
    localparam int IO_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_demux_8085_if bus();

    bus_demux_8085 #(
        .ROM_BASE(5'b00000),
        .RAM_PAGE(8'h20),
        .IO_BASE (4'h0),
        .ROM_WAIT(4'd1),
        .RAM_WAIT(4'd0),
        .IO_WAIT (4'd2)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    // {addr[15:0], io_m_l, rom_csn, ram_csn, io_csn, unmapped, ready}
    typedef logic [21:0] obs_t;
    obs_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: region 0 none, 1 rom, 2 ram, 3 io
    logic [15:0] m_addr;
    logic        m_iom;
    int          m_region;
    logic        m_unm;
    logic        m_ready;
    bit          m_armed;
    int          m_left;

    function automatic int region_of(input logic [15:0] a, input logic iom);
        if (iom) return (a[7:0] / 16 == 0) ? 3 : 0;
        if (a < 16'h0800) return 1;
        if (a >= 16'h2000 && a < 16'h2100) return 2;
        return 0;
    endfunction

    function automatic int waits_of(input int region);
        case (region)
            1: return ROM_W;
            2: return RAM_W;
            3: return IO_W;
            default: return 0;
        endcase
    endfunction

    function automatic obs_t model_obs();
        return {m_addr, m_iom, m_region != 1, m_region != 2, m_region != 3, m_unm, m_ready};
    endfunction

    task automatic step(input bit r, input bit ale, input logic [7:0] a, input logic [7:0] ad,
                        input bit rdn, input bit wrn, input bit iom);
        bit stb;
        @(negedge clk);
        #1;
        rst       = r;
        bus.ALE   = ale;
        bus.A     = a;
        bus.AD    = ad;
        bus.RDn   = rdn;
        bus.WRn   = wrn;
        bus.IO_Mn = iom;
        stb = !rdn || !wrn;
        if (r) begin
            m_addr = '0; m_iom = 1'b0; m_region = 0; m_unm = 1'b0;
            m_ready = 1'b1; m_armed = 0; m_left = 0;
        end else if (ale) begin
            m_addr   = {a, ad};
            m_iom    = iom;
            m_region = region_of({a, ad}, iom);
            m_unm    = (m_region == 0);
            m_ready  = 1'b1;
            m_armed  = 1;
            m_left   = 0;
        end else if (m_armed && stb) begin
            m_armed = 0;
            m_left  = waits_of(m_region);
            if (m_left > 0) m_ready = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_ready = 1'b1;
        end
        exp_q.push_back(model_obs());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 1, 1, 0);
    endtask

    // ALE cycle, gap, strobe of given length, then strobe released.
    task automatic bus_cycle(input logic [7:0] a, input logic [7:0] ad, input bit iom,
                             input bit wr, input int gap, input int len);
        step(0, 1, a, ad, 1, 1, iom);
        idle(gap);
        for (int i = 0; i < len; i++) step(0, 0, a, 8'hzz === 8'h00 ? 8'h00 : ad, wr, !wr, iom);
        step(0, 0, a, ad, 1, 1, iom);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t act, req;
            act = {bus.ADDR, bus.IO_Mn_L, bus.ROM_CSn, bus.RAM_CSn, bus.IO_CSn, bus.UNMAPPED, bus.READY};
            req = exp_q.pop_front();
            checks++;
            if (act !== req) begin
                failures++;
                $display("FAIL outputs t=%0t actual addr=%h iom_l=%b csn(rom,ram,io)=%b unm=%b ready=%b required addr=%h iom_l=%b csn(rom,ram,io)=%b unm=%b ready=%b",
                         $time, act[21:6], act[5], act[4:2], act[1], act[0],
                         req[21:6], req[5], req[4:2], req[1], req[0]);
            end
        end
    end

    initial begin
        bus.ALE = 1'b0; bus.RDn = 1'b1; bus.WRn = 1'b1;
        bus.IO_Mn = 1'b0; bus.A = '0; bus.AD = '0;

        step(1, 0, 8'h00, 8'h00, 1, 1, 0);
        step(1, 0, 8'h00, 8'h00, 1, 1, 0);
        // Stray strobe after reset, no ALE
        step(0, 0, 8'h12, 8'h34, 0, 1, 0);
        step(0, 0, 8'h12, 8'h34, 0, 1, 0);
        idle(1);

        // ROM read, one wait state
        bus_cycle(8'h03, 8'h45, 0, 0, 1, 4);
        idle(1);
        // RAM write, zero wait
        bus_cycle(8'h20, 8'h10, 0, 1, 0, 3);
        // IO read hit, then miss
        bus_cycle(8'h05, 8'h05, 1, 0, 0, 4);
        bus_cycle(8'h15, 8'h15, 1, 0, 0, 4);
        // Both strobes low at once
        step(0, 1, 8'h07, 8'hff, 1, 1, 0);
        step(0, 0, 8'h07, 8'hff, 0, 0, 0);
        step(0, 0, 8'h07, 8'hff, 0, 0, 0);
        idle(2);

        // ALE abort during first IO wait cycle
        step(0, 1, 8'h00, 8'h05, 1, 1, 1);
        step(0, 0, 8'h00, 8'h05, 0, 1, 1);
        step(0, 1, 8'h00, 8'h00, 1, 1, 0);
        step(0, 0, 8'h00, 8'h00, 0, 1, 0);
        idle(3);

        // Reset mid-wait on a ROM cycle
        step(0, 1, 8'h01, 8'h00, 1, 1, 0);
        step(0, 0, 8'h01, 8'h00, 0, 1, 0);
        step(1, 0, 8'h01, 8'h00, 0, 1, 0);
        step(0, 0, 8'h01, 8'h00, 0, 1, 0);
        idle(1);

        // Strobe ending early inside an IO wait
        step(0, 1, 8'h00, 8'h0a, 1, 1, 1);
        step(0, 0, 8'h00, 8'h0a, 1, 0, 1);
        idle(4);

        for (int t = 0; t < 200; t++) begin
            logic [7:0] a, ad;
            bit iom;
            int kind;
            kind = $urandom_range(0, 5);
            a  = 8'($urandom);
            ad = 8'($urandom);
            iom = 0;
            case (kind)
                0: a = 8'($urandom_range(0, 7));
                1: a = 8'h20;
                2: begin iom = 1; ad = 8'($urandom_range(0, 15)); end
                3: iom = 1;
                default: ;
            endcase
            step(0, 1, a, ad, 1, 1, iom);
            for (int c = 0; c < int'($urandom_range(1, 7)); c++) begin
                int r;
                r = $urandom_range(0, 39);
                if (r == 0)
                    step(1, 0, a, ad, 1, 1, iom);
                else if (r == 1)
                    step(0, 1, 8'($urandom), 8'($urandom), 1, 1, 1'($urandom));
                else
                    step(0, 0, a, ad, r[1] ? 1'b1 : 1'b0, 1'($urandom), iom);
            end
            idle($urandom_range(0, 2));
        end

        idle(2);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
